// File: rtl/cand_pkg.sv
// Shared definitions for the candidate bank controller: sizes, field positions, FSM states.
package cand_pkg;

  localparam int CAND_WORD_WIDTH = 16;
  localparam int CAND_ENTRIES    = 8;
  localparam int CNT_W           = 4;
  localparam int IDX_W           = 3;
  localparam int ADDR_W          = 16;

  localparam int ID_MSB  = 15;
  localparam int ID_LSB  = 8;
  localparam int FIT_MSB = 7;
  localparam int FIT_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITE,
    SCAN,
    DONE
  } state_t;

  // Each entry occupies two bytes, so entry i lives at byte address 2*i.
  function automatic logic [ADDR_W-1:0] byte_addr(input logic [IDX_W-1:0] i);
    return ADDR_W'({i, 1'b0});
  endfunction

endpackage

// File: rtl/cand_best_tracker.sv
// Running-maximum tracker over fitness bytes; the first sample loads, later ones replace only on strictly greater.
module cand_best_tracker
  import cand_pkg::*;
#(
  parameter int WORD_WIDTH = CAND_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  sample_en,
  input  logic                  first,
  input  logic                  commit,
  input  logic [WORD_WIDTH-1:0] sample_data,
  input  logic [IDX_W-1:0]      sample_idx,
  output logic                  best_valid,
  output logic [WORD_WIDTH-1:0] best_data,
  output logic [IDX_W-1:0]      best_idx
);

  logic better;

  assign better = first || (sample_data[FIT_MSB:FIT_LSB] > best_data[FIT_MSB:FIT_LSB]);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      best_valid <= 1'b0;
      best_data  <= '0;
      best_idx   <= '0;
    end else begin
      if (sample_en && better) begin
        best_data <= sample_data;
        best_idx  <= sample_idx;
      end
      if (commit) begin
        best_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cand_bank_ctrl.sv
// Candidate list controller over an external 16-byte bank: insert, best-fitness scan, clear.
// Define CAND_DEDUP_EN to look up node ids before inserting and overwrite a matching entry.
module cand_bank_ctrl
  import cand_pkg::*;
#(
  parameter int WORD_WIDTH = CAND_WORD_WIDTH,
  parameter int ENTRIES    = CAND_ENTRIES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  input  logic [WORD_WIDTH-1:0] ins_data,
  input  logic                  scan_start,
  output logic                  scan_busy,
  output logic                  scan_done,
  output logic                  best_valid,
  output logic [WORD_WIDTH-1:0] best_data,
  output logic [IDX_W-1:0]      best_idx,
  output logic [CNT_W-1:0]      cand_count,
  output logic                  full,
  output logic                  empty,
  output logic                  mem_wr_en,
  output logic [ADDR_W-1:0]     mem_index,
  output logic [WORD_WIDTH-1:0] mem_data_in,
  input  logic [WORD_WIDTH-1:0] mem_data_out
);

`ifdef CAND_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  state_t                state, state_n;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      slot;
  logic                  append;
  logic [WORD_WIDTH-1:0] word;
  logic                  accept_ins;
  logic                  accept_scan;
  logic                  last;
  logic                  id_match;

  assign full        = (cand_count == CNT_W'(ENTRIES));
  assign empty       = (cand_count == '0);
  assign last        = ((CNT_W'(idx) + CNT_W'(1)) == cand_count);
  assign ins_ready   = !rst && (state == IDLE) && !full && !clr && !scan_start;
  assign accept_ins  = ins_valid && ins_ready;
  assign accept_scan = !rst && !clr && (state == IDLE) && scan_start;
  assign id_match    = DEDUP && (state == LOOKUP) && !empty &&
                       (mem_data_out[ID_MSB:ID_LSB] == word[ID_MSB:ID_LSB]);

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept_scan) begin
          state_n = empty ? DONE : SCAN;
        end else if (accept_ins) begin
          state_n = DEDUP ? LOOKUP : WRITE;
        end
      end
      LOOKUP:  if (id_match || last || empty) state_n = WRITE;
      WRITE:   state_n = IDLE;
      SCAN:    if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (clr) begin
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cand_count <= '0;
      idx        <= '0;
      slot       <= '0;
      append     <= 1'b0;
    end else begin
      state <= state_n;
      if (clr) begin
        cand_count <= '0;
      end else if ((state == WRITE) && append && !full) begin
        cand_count <= cand_count + 1'b1;
      end
      if (accept_ins || accept_scan) begin
        idx <= '0;
      end else if ((state == LOOKUP) || (state == SCAN)) begin
        idx <= idx + 1'b1;
      end
      // Default target is the next free slot; the first id match redirects it.
      if (accept_ins) begin
        slot   <= cand_count[IDX_W-1:0];
        append <= 1'b1;
      end else if (id_match) begin
        slot   <= idx;
        append <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept_ins) begin
      word <= ins_data;
    end
  end

  always_comb begin
    scan_busy   = 1'b0;
    scan_done   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_index   = '0;
    mem_data_in = '0;
    if (!rst) begin
      case (state)
        LOOKUP: begin
          scan_busy = 1'b1;
          mem_index = byte_addr(idx);
        end
        WRITE: begin
          mem_wr_en   = !clr;
          mem_index   = byte_addr(slot);
          mem_data_in = word;
        end
        SCAN: begin
          scan_busy = 1'b1;
          mem_index = byte_addr(idx);
        end
        DONE: begin
          scan_busy = 1'b1;
          scan_done = !clr;
        end
        default: ;
      endcase
    end
  end

  cand_best_tracker #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_best (
    .clk        (clk),
    .rst        (rst),
    .clear      (clr || accept_scan),
    .sample_en  (state == SCAN),
    .first      (idx == '0),
    .commit     ((state == SCAN) && last),
    .sample_data(mem_data_out),
    .sample_idx (idx),
    .best_valid (best_valid),
    .best_data  (best_data),
    .best_idx   (best_idx)
  );

endmodule
